// File: rtl/vx_tex_addr_seq_if.sv
// rtl/vx_tex_addr_seq_if.sv - request and response bundles for the texture address sequencer
interface vx_tex_addr_seq_req_if #(
  parameter int NUM_REQS  = 4,
  parameter int LOD_BITS  = 4,
  parameter int REQ_INFOW = 1
);
  logic                                   req_valid;
  logic                                   req_ready;
  logic [NUM_REQS-1:0]                    req_tmask;
  logic [1:0][NUM_REQS-1:0][31:0]         req_coords;
  logic                                   req_filter;
  logic [1:0][1:0]                        req_wraps;
  logic [1:0]                             req_lgstride;
  logic [31:0]                            req_baseaddr;
  logic [NUM_REQS-1:0][LOD_BITS-1:0]      req_lod;
  logic [NUM_REQS-1:0][31:0]              req_mipoff;
  logic [NUM_REQS-1:0][1:0][LOD_BITS-1:0] req_logdims;
  logic [REQ_INFOW-1:0]                   req_info;

  modport master (
    output req_valid, req_tmask, req_coords, req_filter, req_wraps, req_lgstride,
           req_baseaddr, req_lod, req_mipoff, req_logdims, req_info,
    input  req_ready
  );
  modport slave (
    input  req_valid, req_tmask, req_coords, req_filter, req_wraps, req_lgstride,
           req_baseaddr, req_lod, req_mipoff, req_logdims, req_info,
    output req_ready
  );
endinterface

interface vx_tex_addr_seq_rsp_if #(
  parameter int NUM_REQS   = 4,
  parameter int OUT_LANES  = 1,
  parameter int BLEND_FRAC = 8,
  parameter int REQ_INFOW  = 1
);
  localparam int G  = NUM_REQS / OUT_LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  logic                                    rsp_valid;
  logic                                    rsp_ready;
  logic [OUT_LANES-1:0]                    rsp_tmask;
  logic [GW-1:0]                           rsp_group;
  logic                                    rsp_last;
  logic                                    rsp_filter;
  logic [1:0]                              rsp_lgstride;
  logic [OUT_LANES-1:0][3:0][31:0]         rsp_addr;
  logic [OUT_LANES-1:0][1:0][BLEND_FRAC-1:0] rsp_blends;
  logic [REQ_INFOW-1:0]                    rsp_info;

  modport master (
    output rsp_valid, rsp_tmask, rsp_group, rsp_last, rsp_filter, rsp_lgstride,
           rsp_addr, rsp_blends, rsp_info,
    input  rsp_ready
  );
  modport slave (
    input  rsp_valid, rsp_tmask, rsp_group, rsp_last, rsp_filter, rsp_lgstride,
           rsp_addr, rsp_blends, rsp_info,
    output rsp_ready
  );
endinterface

// File: rtl/vx_tex_addr_seq.sv
// rtl/vx_tex_addr_seq.sv - texture texel address generator and group sequencer (MIRROR wrap under TEX_ADDR_MIRROR_EN)
module vx_tex_addr_seq #(
  parameter int NUM_REQS   = 4,
  parameter int OUT_LANES  = 1,
  parameter int FXD_FRAC   = 20,
  parameter int BLEND_FRAC = 8,
  parameter int LOD_BITS   = 4,
  parameter int REQ_INFOW  = 1
) (
  input logic                   clk,
  input logic                   reset,
  vx_tex_addr_seq_req_if.slave  req,
  vx_tex_addr_seq_rsp_if.master rsp
);
  localparam int G      = NUM_REQS / OUT_LANES;
  localparam int GW     = (G > 1) ? $clog2(G) : 1;
  localparam int SH_MAX = FXD_FRAC - BLEND_FRAC;

  typedef enum logic {IDLE, ISSUE} state_e;

  // level of detail per axis, floored at zero
  function automatic logic [LOD_BITS-1:0] lane_ld(input logic [LOD_BITS-1:0] dim, input logic [LOD_BITS-1:0] lod);
    return (dim >= lod) ? dim - lod : '0;
  endfunction

  // half-texel offset toward the lower or upper bilinear neighbour
  function automatic logic [31:0] coord_edge(input logic [31:0] c, input logic [LOD_BITS-1:0] ld,
                                             input logic filt, input logic upper);
    logic [31:0] delta;
    delta = filt ? ((32'd1 << (FXD_FRAC - 1)) >> ld) : 32'd0;
    return upper ? c + delta : c - delta;
  endfunction

  // fold a signed fixed-point coordinate into [0, 1) according to the wrap mode
  function automatic logic [FXD_FRAC-1:0] wrap_coord(input logic [31:0] c, input logic [1:0] mode);
    logic [FXD_FRAC-1:0] r;
    case (mode)
`ifdef TEX_ADDR_MIRROR_EN
      2'd1:    r = c[FXD_FRAC-1:0];
      2'd2:    r = c[FXD_FRAC] ? ~c[FXD_FRAC-1:0] : c[FXD_FRAC-1:0];
`else
      2'd1, 2'd2: r = c[FXD_FRAC-1:0];
`endif
      default: begin
        if (c[31])                         r = '0;
        else if (c[30:FXD_FRAC] != '0)     r = '1;
        else                               r = c[FXD_FRAC-1:0];
      end
    endcase
    return r;
  endfunction

  // deep mips can need more than the available fraction; stop shifting at zero
  function automatic int frac_shift(input logic [LOD_BITS-1:0] ld);
    return (int'(ld) >= SH_MAX) ? 0 : SH_MAX - int'(ld);
  endfunction

  function automatic logic [31:0] texel_idx(input logic [FXD_FRAC-1:0] w, input logic [LOD_BITS-1:0] ld);
    return 32'(w >> (frac_shift(ld) + BLEND_FRAC));
  endfunction

  function automatic logic [BLEND_FRAC-1:0] blend_w(input logic [FXD_FRAC-1:0] w, input logic [LOD_BITS-1:0] ld);
    return BLEND_FRAC'(w >> frac_shift(ld));
  endfunction

  function automatic logic [31:0] texel_addr(input logic [31:0] base, input logic [31:0] mip,
                                             input logic [31:0] x, input logic [31:0] y,
                                             input logic [LOD_BITS-1:0] ldu, input logic [1:0] lgs);
    return base + mip + (y << (int'(ldu) + int'(lgs))) + (x << lgs);
  endfunction

  function automatic logic [G-1:0] group_mask(input logic [NUM_REQS-1:0] m);
    logic [G-1:0] r;
    for (int g = 0; g < G; g++) r[g] = |m[g*OUT_LANES +: OUT_LANES];
    return r;
  endfunction

  // lowest active group at or above 'from'; group 0 when none remain
  function automatic logic [GW-1:0] next_group(input logic [G-1:0] gm, input int from);
    logic [GW-1:0] r;
    logic          found;
    r     = '0;
    found = 1'b0;
    for (int g = 0; g < G; g++) begin
      if (!found && g >= from && gm[g]) begin
        r     = GW'(g);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [GW-1:0] last_group(input logic [G-1:0] gm);
    logic [GW-1:0] r;
    r = '0;
    for (int g = 0; g < G; g++) if (gm[g]) r = GW'(g);
    return r;
  endfunction

  logic                                   s0_valid_q, s0_valid_d;
  logic [NUM_REQS-1:0][1:0][FXD_FRAC-1:0] s0_lo_q, s0_lo_d, s0_hi_q, s0_hi_d;
  logic [NUM_REQS-1:0][1:0][LOD_BITS-1:0] s0_ld_q, s0_ld_d;
  logic [NUM_REQS-1:0][31:0]              s0_mipoff_q, s0_mipoff_d;
  logic [NUM_REQS-1:0]                    s0_tmask_q, s0_tmask_d;
  logic                                   s0_filter_q, s0_filter_d;
  logic [1:0]                             s0_lgstride_q, s0_lgstride_d;
  logic [31:0]                            s0_base_q, s0_base_d;
  logic [REQ_INFOW-1:0]                   s0_info_q, s0_info_d;

  state_e                                    state_q, state_d;
  logic                                      rsp_valid_q, rsp_valid_d;
  logic [GW-1:0]                             grp_q, grp_d;
  logic                                      last_q, last_d;
  logic [NUM_REQS-1:0][3:0][31:0]            s1_addr_q, s1_addr_d;
  logic [NUM_REQS-1:0][1:0][BLEND_FRAC-1:0]  s1_blends_q, s1_blends_d;
  logic [NUM_REQS-1:0]                       s1_tmask_q, s1_tmask_d;
  logic                                      s1_filter_q, s1_filter_d;
  logic [1:0]                                s1_lgstride_q, s1_lgstride_d;
  logic [REQ_INFOW-1:0]                      s1_info_q, s1_info_d;

  logic         rsp_fire, s1_load, req_ready_w;
  logic [G-1:0] gm_s0, gm_s1;

  assign rsp_fire    = rsp_valid_q && rsp.rsp_ready;
  assign s1_load     = s0_valid_q && (state_q == IDLE || (rsp_fire && last_q));
  assign req_ready_w = !s0_valid_q || s1_load;
  assign req.req_ready = req_ready_w;
  assign gm_s0 = group_mask(s0_tmask_q);
  assign gm_s1 = group_mask(s1_tmask_q);

  // S0 capture: neighbour coordinates wrapped into the unit range
  always_comb begin
    s0_valid_d    = s0_valid_q;
    s0_lo_d       = s0_lo_q;
    s0_hi_d       = s0_hi_q;
    s0_ld_d       = s0_ld_q;
    s0_mipoff_d   = s0_mipoff_q;
    s0_tmask_d    = s0_tmask_q;
    s0_filter_d   = s0_filter_q;
    s0_lgstride_d = s0_lgstride_q;
    s0_base_d     = s0_base_q;
    s0_info_d     = s0_info_q;
    if (req_ready_w) s0_valid_d = req.req_valid;
    if (req_ready_w && req.req_valid) begin
      s0_tmask_d    = req.req_tmask;
      s0_filter_d   = req.req_filter;
      s0_lgstride_d = req.req_lgstride;
      s0_base_d     = req.req_baseaddr;
      s0_info_d     = req.req_info;
      s0_mipoff_d   = req.req_mipoff;
      for (int i = 0; i < NUM_REQS; i++) begin
        for (int j = 0; j < 2; j++) begin
          s0_ld_d[i][j] = lane_ld(req.req_logdims[i][j], req.req_lod[i]);
          s0_lo_d[i][j] = wrap_coord(coord_edge(req.req_coords[j][i], lane_ld(req.req_logdims[i][j], req.req_lod[i]),
                                                req.req_filter, 1'b0), req.req_wraps[j]);
          s0_hi_d[i][j] = wrap_coord(coord_edge(req.req_coords[j][i], lane_ld(req.req_logdims[i][j], req.req_lod[i]),
                                                req.req_filter, 1'b1), req.req_wraps[j]);
        end
      end
    end
  end

  // S1 fill: four texel addresses and blend weights for every lane
  always_comb begin
    s1_addr_d     = s1_addr_q;
    s1_blends_d   = s1_blends_q;
    s1_tmask_d    = s1_tmask_q;
    s1_filter_d   = s1_filter_q;
    s1_lgstride_d = s1_lgstride_q;
    s1_info_d     = s1_info_q;
    if (s1_load) begin
      s1_tmask_d    = s0_tmask_q;
      s1_filter_d   = s0_filter_q;
      s1_lgstride_d = s0_lgstride_q;
      s1_info_d     = s0_info_q;
      for (int i = 0; i < NUM_REQS; i++) begin
        s1_addr_d[i][0] = texel_addr(s0_base_q, s0_mipoff_q[i], texel_idx(s0_lo_q[i][0], s0_ld_q[i][0]),
                                     texel_idx(s0_lo_q[i][1], s0_ld_q[i][1]), s0_ld_q[i][0], s0_lgstride_q);
        s1_addr_d[i][1] = texel_addr(s0_base_q, s0_mipoff_q[i], texel_idx(s0_hi_q[i][0], s0_ld_q[i][0]),
                                     texel_idx(s0_lo_q[i][1], s0_ld_q[i][1]), s0_ld_q[i][0], s0_lgstride_q);
        s1_addr_d[i][2] = texel_addr(s0_base_q, s0_mipoff_q[i], texel_idx(s0_lo_q[i][0], s0_ld_q[i][0]),
                                     texel_idx(s0_hi_q[i][1], s0_ld_q[i][1]), s0_ld_q[i][0], s0_lgstride_q);
        s1_addr_d[i][3] = texel_addr(s0_base_q, s0_mipoff_q[i], texel_idx(s0_hi_q[i][0], s0_ld_q[i][0]),
                                     texel_idx(s0_hi_q[i][1], s0_ld_q[i][1]), s0_ld_q[i][0], s0_lgstride_q);
        for (int j = 0; j < 2; j++)
          s1_blends_d[i][j] = s0_filter_q ? blend_w(s0_lo_q[i][j], s0_ld_q[i][j]) : '0;
      end
    end
  end

  // sequencer: a fresh load always starts at its first active group, even on the last beat of the previous one
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    grp_d       = grp_q;
    last_d      = last_q;
    if (s1_load) begin
      state_d     = ISSUE;
      rsp_valid_d = 1'b1;
      grp_d       = next_group(gm_s0, 0);
      last_d      = (next_group(gm_s0, 0) == last_group(gm_s0));
    end else if (rsp_fire) begin
      if (last_q) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        grp_d       = '0;
        last_d      = 1'b0;
      end else begin
        grp_d  = next_group(gm_s1, int'(grp_q) + 1);
        last_d = (next_group(gm_s1, int'(grp_q) + 1) == last_group(gm_s1));
      end
    end
  end

  // control state and registered beat qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q  <= 1'b0;
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      grp_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      grp_q       <= grp_d;
      last_q      <= last_d;
    end
  end

  // pipeline payload, qualified by the valid flags above
  always_ff @(posedge clk) begin
    s0_lo_q       <= s0_lo_d;
    s0_hi_q       <= s0_hi_d;
    s0_ld_q       <= s0_ld_d;
    s0_mipoff_q   <= s0_mipoff_d;
    s0_tmask_q    <= s0_tmask_d;
    s0_filter_q   <= s0_filter_d;
    s0_lgstride_q <= s0_lgstride_d;
    s0_base_q     <= s0_base_d;
    s0_info_q     <= s0_info_d;
    s1_addr_q     <= s1_addr_d;
    s1_blends_q   <= s1_blends_d;
    s1_tmask_q    <= s1_tmask_d;
    s1_filter_q   <= s1_filter_d;
    s1_lgstride_q <= s1_lgstride_d;
    s1_info_q     <= s1_info_d;
  end

  // beat payload: select the current group's lanes from the S1 buffer
  always_comb begin
    rsp.rsp_tmask  = '0;
    rsp.rsp_addr   = '0;
    rsp.rsp_blends = '0;
    for (int g = 0; g < G; g++) begin
      if (grp_q == GW'(g)) begin
        rsp.rsp_tmask  = s1_tmask_q[g*OUT_LANES +: OUT_LANES];
        rsp.rsp_addr   = s1_addr_q[g*OUT_LANES +: OUT_LANES];
        rsp.rsp_blends = s1_blends_q[g*OUT_LANES +: OUT_LANES];
      end
    end
  end

  assign rsp.rsp_valid    = rsp_valid_q;
  assign rsp.rsp_group    = grp_q;
  assign rsp.rsp_last     = last_q;
  assign rsp.rsp_filter   = s1_filter_q;
  assign rsp.rsp_lgstride = s1_lgstride_q;
  assign rsp.rsp_info     = s1_info_q;

endmodule

// File: tb/tb_vx_tex_addr_seq.sv
// tb/tb_vx_tex_addr_seq.sv - directed bench for vx_tex_addr_seq (G=4 and G=1 instances)
module tb_vx_tex_addr_seq;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vx_tex_addr_seq_req_if #(.NUM_REQS(4), .LOD_BITS(4), .REQ_INFOW(1)) rq1 ();
  vx_tex_addr_seq_rsp_if #(.NUM_REQS(4), .OUT_LANES(1), .BLEND_FRAC(8), .REQ_INFOW(1)) rs1 ();
  vx_tex_addr_seq_req_if #(.NUM_REQS(4), .LOD_BITS(4), .REQ_INFOW(1)) rq4 ();
  vx_tex_addr_seq_rsp_if #(.NUM_REQS(4), .OUT_LANES(4), .BLEND_FRAC(8), .REQ_INFOW(1)) rs4 ();

  vx_tex_addr_seq #(.NUM_REQS(4), .OUT_LANES(1), .FXD_FRAC(20), .BLEND_FRAC(8), .LOD_BITS(4), .REQ_INFOW(1))
    dut1 (.clk(clk), .reset(reset), .req(rq1), .rsp(rs1));
  vx_tex_addr_seq #(.NUM_REQS(4), .OUT_LANES(4), .FXD_FRAC(20), .BLEND_FRAC(8), .LOD_BITS(4), .REQ_INFOW(1))
    dut4 (.clk(clk), .reset(reset), .req(rq4), .rsp(rs4));

  int          nb;
  int          b_cyc  [16];
  logic [1:0]  b_grp  [16];
  logic        b_last [16];
  logic        b_mask [16];
  logic        b_info [16];
  logic [31:0] b_addr [16][4];
  logic [7:0]  b_bl   [16][2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [3:0] mask, input logic filt, input logic [31:0] u, input logic [31:0] v,
                           input logic [1:0] wu, input logic [1:0] wv, input logic info);
    rq1.req_tmask    = mask;
    rq1.req_filter   = filt;
    rq1.req_wraps[0] = wu;
    rq1.req_wraps[1] = wv;
    rq1.req_lgstride = 2'd2;
    rq1.req_baseaddr = 32'h1000;
    rq1.req_info     = info;
    for (int i = 0; i < 4; i++) begin
      rq1.req_coords[0][i]  = u;
      rq1.req_coords[1][i]  = v;
      rq1.req_lod[i]        = 4'd0;
      rq1.req_mipoff[i]     = 32'd0;
      rq1.req_logdims[i][0] = 4'd4;
      rq1.req_logdims[i][1] = 4'd4;
    end
  endtask

  task automatic send1(output int acc);
    bit ok = 1'b0;
    acc = -1;
    rq1.req_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (rq1.req_ready) begin
        acc = cyc;
        ok  = 1'b1;
      end
      tick();
    end
    rq1.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept got=timeout expected=req_ready within 20 cycles");
    end
  endtask

  task automatic collect1(input int nlast);
    int seen = 0;
    nb = 0;
    for (int k = 0; k < 40 && seen < nlast; k++) begin
      if (rs1.rsp_valid && rs1.rsp_ready && nb < 16) begin
        b_cyc[nb]  = cyc;
        b_grp[nb]  = rs1.rsp_group;
        b_last[nb] = rs1.rsp_last;
        b_mask[nb] = rs1.rsp_tmask[0];
        b_info[nb] = rs1.rsp_info[0];
        for (int a = 0; a < 4; a++) b_addr[nb][a] = rs1.rsp_addr[0][a];
        b_bl[nb][0] = rs1.rsp_blends[0][0];
        b_bl[nb][1] = rs1.rsp_blends[0][1];
        if (rs1.rsp_last) seen++;
        nb++;
      end
      tick();
    end
    checks++;
    if (seen < nlast) begin
      errors++;
      $display("FAIL collect_last got=%0d expected=%0d last beats", seen, nlast);
    end
  endtask

  task automatic test_reset();
    checks++; if (rs1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b expected=0", rs1.rsp_valid); end
    checks++; if (rs1.rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got=%b expected=0", rs1.rsp_last); end
    checks++; if (rs1.rsp_group !== 2'd0) begin errors++; $display("FAIL reset_rsp_group got=%0d expected=0", rs1.rsp_group); end
    checks++; if (rq1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b expected=1", rq1.req_ready); end
  endtask

  task automatic test_point();
    int acc;
    rs1.rsp_ready = 1'b1;
    set_lanes(4'b0001, 1'b0, 32'h80000, 32'h80000, 2'd0, 2'd0, 1'b0);
    send1(acc);
    collect1(1);
    checks++; if (nb !== 1) begin errors++; $display("FAIL point_beats got=%0d expected=1", nb); end
    checks++; if (b_cyc[0] - acc !== 2) begin errors++; $display("FAIL point_latency got=%0d expected=2", b_cyc[0] - acc); end
    checks++; if (b_grp[0] !== 2'd0 || b_last[0] !== 1'b1 || b_mask[0] !== 1'b1) begin
      errors++; $display("FAIL point_ctrl got=grp%0d last%b mask%b expected=grp0 last1 mask1", b_grp[0], b_last[0], b_mask[0]); end
    for (int a = 0; a < 4; a++) begin
      checks++; if (b_addr[0][a] !== 32'h1220) begin errors++; $display("FAIL point_addr%0d got=%h expected=00001220", a, b_addr[0][a]); end
    end
    checks++; if (b_bl[0][0] !== 8'h00 || b_bl[0][1] !== 8'h00) begin
      errors++; $display("FAIL point_blends got=%h/%h expected=00/00", b_bl[0][0], b_bl[0][1]); end
  endtask

  task automatic test_bilinear();
    int acc;
    logic [31:0] ea [4];
    ea[0] = 32'h11DC; ea[1] = 32'h11E0; ea[2] = 32'h121C; ea[3] = 32'h1220;
    set_lanes(4'b0001, 1'b1, 32'h80000, 32'h80000, 2'd0, 2'd0, 1'b0);
    send1(acc);
    collect1(1);
    checks++; if (nb !== 1) begin errors++; $display("FAIL bilin_beats got=%0d expected=1", nb); end
    for (int a = 0; a < 4; a++) begin
      checks++; if (b_addr[0][a] !== ea[a]) begin errors++; $display("FAIL bilin_addr%0d got=%h expected=%h", a, b_addr[0][a], ea[a]); end
    end
    checks++; if (b_bl[0][0] !== 8'h80 || b_bl[0][1] !== 8'h80) begin
      errors++; $display("FAIL bilin_blends got=%h/%h expected=80/80", b_bl[0][0], b_bl[0][1]); end
  endtask

  task automatic test_wrap();
    int acc;
    logic [31:0] tu [4];
    logic [1:0]  tw [4];
    logic [31:0] te [4];
    tu[0] = 32'h180000;  tw[0] = 2'd1; te[0] = 32'h1220;
    tu[1] = -32'sd16;    tw[1] = 2'd0; te[1] = 32'h1200;
    tu[2] = 32'h100000;  tw[2] = 2'd0; te[2] = 32'h123C;
    tu[3] = 32'h140000;  tw[3] = 2'd2;
`ifdef TEX_ADDR_MIRROR_EN
    te[3] = 32'h122C;
`else
    te[3] = 32'h1210;
`endif
    for (int t = 0; t < 4; t++) begin
      set_lanes(4'b0001, 1'b0, tu[t], 32'h80000, tw[t], 2'd0, 1'b0);
      send1(acc);
      collect1(1);
      checks++; if (nb !== 1 || b_addr[0][0] !== te[t]) begin
        errors++; $display("FAIL wrap_case%0d got=beats%0d addr%h expected=beats1 addr%h", t, nb, b_addr[0][0], te[t]); end
    end
  endtask

  task automatic test_mask();
    int acc;
    set_lanes(4'b1010, 1'b0, 32'h80000, 32'h80000, 2'd0, 2'd0, 1'b1);
    send1(acc);
    collect1(1);
    checks++; if (nb !== 2) begin errors++; $display("FAIL mask1010_beats got=%0d expected=2", nb); end
    checks++; if (b_grp[0] !== 2'd1 || b_last[0] !== 1'b0 || b_mask[0] !== 1'b1) begin
      errors++; $display("FAIL mask1010_beat0 got=grp%0d last%b mask%b expected=grp1 last0 mask1", b_grp[0], b_last[0], b_mask[0]); end
    checks++; if (b_grp[1] !== 2'd3 || b_last[1] !== 1'b1 || b_mask[1] !== 1'b1) begin
      errors++; $display("FAIL mask1010_beat1 got=grp%0d last%b mask%b expected=grp3 last1 mask1", b_grp[1], b_last[1], b_mask[1]); end
    set_lanes(4'b0000, 1'b0, 32'h80000, 32'h80000, 2'd0, 2'd0, 1'b1);
    send1(acc);
    collect1(1);
    checks++; if (nb !== 1) begin errors++; $display("FAIL mask0_beats got=%0d expected=1", nb); end
    checks++; if (b_grp[0] !== 2'd0 || b_last[0] !== 1'b1 || b_mask[0] !== 1'b0 || b_info[0] !== 1'b1) begin
      errors++; $display("FAIL mask0_beat got=grp%0d last%b mask%b info%b expected=grp0 last1 mask0 info1",
                         b_grp[0], b_last[0], b_mask[0], b_info[0]); end
  endtask

  task automatic test_stall();
    int acc;
    rs1.rsp_ready = 1'b0;
    set_lanes(4'b1111, 1'b0, 32'h80000, 32'h80000, 2'd0, 2'd0, 1'b0);
    send1(acc);
    set_lanes(4'b1111, 1'b0, 32'h0, 32'h80000, 2'd0, 2'd0, 1'b1);
    send1(acc);
    checks++; if (rq1.req_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got=%b expected=0", rq1.req_ready); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rs1.rsp_valid !== 1'b1 || rs1.rsp_group !== 2'd0 || rs1.rsp_last !== 1'b0 ||
          rs1.rsp_addr[0][0] !== 32'h1220 || rq1.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got=v%b grp%0d last%b addr%h rdy%b expected=v1 grp0 last0 addr00001220 rdy0",
                 k, rs1.rsp_valid, rs1.rsp_group, rs1.rsp_last, rs1.rsp_addr[0][0], rq1.req_ready);
      end
      tick();
    end
    rs1.rsp_ready = 1'b1;
    collect1(2);
    checks++; if (nb !== 8) begin errors++; $display("FAIL stall_beats got=%0d expected=8", nb); end
    for (int k = 0; k < 8 && k < nb; k++) begin
      checks++;
      if (b_grp[k] !== 2'(k % 4) || b_info[k] !== (k >= 4) || b_last[k] !== (k == 3 || k == 7) ||
          b_cyc[k] !== b_cyc[0] + k || b_addr[k][0] !== ((k < 4) ? 32'h1220 : 32'h1200)) begin
        errors++;
        $display("FAIL stall_beat%0d got=grp%0d info%b last%b dcyc%0d addr%h expected=grp%0d info%b last%b dcyc%0d addr%h",
                 k, b_grp[k], b_info[k], b_last[k], b_cyc[k] - b_cyc[0], b_addr[k][0],
                 k % 4, k >= 4, (k == 3 || k == 7), k, (k < 4) ? 32'h1220 : 32'h1200);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    int acc;
    int cnt = 0;
    bit hit = 1'b0;
    rs1.rsp_ready = 1'b1;
    set_lanes(4'b1111, 1'b0, 32'h80000, 32'h80000, 2'd0, 2'd0, 1'b0);
    send1(acc);
    for (int k = 0; k < 20 && !hit; k++) begin
      if (rs1.rsp_valid && rs1.rsp_group == 2'd1) hit = 1'b1;
      else tick();
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got=timeout expected=group 1 valid"); end
    rs1.rsp_ready = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (rs1.rsp_valid !== 1'b0 || rs1.rsp_last !== 1'b0 || rs1.rsp_group !== 2'd0) begin
      errors++; $display("FAIL rstmid_clear got=v%b last%b grp%0d expected=v0 last0 grp0", rs1.rsp_valid, rs1.rsp_last, rs1.rsp_group); end
    reset = 1'b0;
    checks++; if (rq1.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b expected=1", rq1.req_ready); end
    rs1.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (rs1.rsp_valid) cnt++;
      tick();
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rstmid_no_beats got=%0d expected=0", cnt); end
  endtask

  task automatic test_back_to_back();
    int          n = 0;
    int          start;
    int          gc [8];
    logic [31:0] ga [8];
    logic        gl [8];
    logic [3:0]  gm [8];
    rs4.rsp_ready = 1'b1;
    start = cyc;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        for (int i = 0; i < 4; i++) rq4.req_coords[0][i] = 32'(c) << 16;
        rq4.req_valid = 1'b1;
        checks++; if (rq4.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b expected=1", c, rq4.req_ready); end
      end else begin
        rq4.req_valid = 1'b0;
      end
      if (rs4.rsp_valid && n < 8) begin
        gc[n] = cyc;
        ga[n] = rs4.rsp_addr[3][0];
        gl[n] = rs4.rsp_last;
        gm[n] = rs4.rsp_tmask;
        n++;
      end
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_beats got=%0d expected=4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      checks++;
      if (gc[k] !== start + 2 + k || ga[k] !== 32'h1200 + 32'(4 * k) || gl[k] !== 1'b1 || gm[k] !== 4'hF) begin
        errors++;
        $display("FAIL b2b_beat%0d got=cyc+%0d addr%h last%b mask%h expected=cyc+%0d addr%h last1 maskf",
                 k, gc[k] - start, ga[k], gl[k], gm[k], 2 + k, 32'h1200 + 32'(4 * k));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rq1.req_valid = 1'b0;
    rs1.rsp_ready = 1'b0;
    set_lanes(4'b0001, 1'b0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
    rq4.req_valid    = 1'b0;
    rq4.req_tmask    = 4'hF;
    rq4.req_filter   = 1'b0;
    rq4.req_wraps[0] = 2'd0;
    rq4.req_wraps[1] = 2'd0;
    rq4.req_lgstride = 2'd2;
    rq4.req_baseaddr = 32'h1000;
    rq4.req_info     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rq4.req_coords[0][i]  = 32'h0;
      rq4.req_coords[1][i]  = 32'h80000;
      rq4.req_lod[i]        = 4'd0;
      rq4.req_mipoff[i]     = 32'd0;
      rq4.req_logdims[i][0] = 4'd4;
      rq4.req_logdims[i][1] = 4'd4;
    end
    rs4.rsp_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    test_reset();
    test_point();
    test_bilinear();
    test_wrap();
    test_mask();
    test_stall();
    test_reset_mid_issue();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vx_tex_addr_seq.md
VX_TEX_ADDR_SEQ -- requirements
Module: VX_tex_addr_seq

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, meaning lanes per request.
REQ-002 SHALL have parameter OUT_LANES, default 1, meaning lanes per output beat; NUM_REQS % OUT_LANES == 0.
REQ-003 SHALL have parameter FXD_FRAC, default 20, meaning coordinate fraction bits; coords are 32-bit signed two's complement.
REQ-004 SHALL have parameter BLEND_FRAC, default 8, meaning blend weight bits.
REQ-005 SHALL have parameter LOD_BITS, default 4, meaning width of lod and log-dimension fields.
REQ-006 SHALL have parameter REQ_INFOW, default 1, meaning opaque tag width.
REQ-007 SHALL define the following, with G = NUM_REQS/OUT_LANES and GW = max(1, clog2(G)).
REQ-008 SHALL have ports clk (in, 1) and reset (in, 1); one clock; reset is synchronous and active-high.
REQ-009 SHALL have request ports:
- req_valid (in, 1); req_ready (out, 1).
- req_tmask (in, NUM_REQS): lane mask.
- req_coords (in, [2][NUM_REQS][32]): u, v.
- req_filter (in, 1): 0 point, 1 bilinear.
- req_wraps (in, [2][2]): 0 CLAMP, 1 REPEAT, 2 MIRROR, 3 = CLAMP.
- req_lgstride (in, 2): log2 texel bytes.
- req_baseaddr (in, 32).
- req_lod (in, [NUM_REQS][LOD_BITS]).
- req_mipoff (in, [NUM_REQS][32]).
- req_logdims (in, [NUM_REQS][2][LOD_BITS]).
- req_info (in, REQ_INFOW).
REQ-010 SHALL have response ports:
- rsp_valid (out, 1); rsp_ready (in, 1).
- rsp_tmask (out, OUT_LANES).
- rsp_group (out, GW).
- rsp_last (out, 1).
- rsp_filter (out, 1).
- rsp_lgstride (out, 2).
- rsp_addr (out, [OUT_LANES][4][32]).
- rsp_blends (out, [OUT_LANES][2][BLEND_FRAC]).
- rsp_info (out, REQ_INFOW).

Function
REQ-011 SHALL compute per lane i, axis j: ld = logdims[i][j] - lod[i], saturating at 0.
REQ-012 SHALL compute delta = 2^(FXD_FRAC-1) >> ld.
- Bilinear: lo = c - delta, hi = c + delta.
- Point: lo = hi = c.
REQ-013 SHALL wrap each of lo and hi to FXD_FRAC bits:
- CLAMP: negative -> 0; >= 2^FXD_FRAC -> 2^FXD_FRAC - 1; else unchanged.
- REPEAT: low FXD_FRAC bits.
- MIRROR: low FXD_FRAC bits, bitwise inverted when bit FXD_FRAC is 1.
REQ-014 SHALL compute s = wrapped >> (FXD_FRAC - BLEND_FRAC - ld), texel index = s >> BLEND_FRAC, and blend[j] = low BLEND_FRAC bits of s(lo) in bilinear mode, 0 in point mode.
REQ-015 SHALL compute addr = base + mipoff + (y << (ld_u + lgstride)) + (x << lgstride), modulo 2^32.
- addr[0] = (xlo, ylo); addr[1] = (xhi, ylo); addr[2] = (xlo, yhi); addr[3] = (xhi, yhi).
REQ-016 SHALL be a two-register pipeline:
- S0 register holds wrapped coords and control.
- S1 buffer holds the full computed request: all lanes, addresses, blends, info.
REQ-017 SHALL run a sequencer FSM on S1 with states IDLE and ISSUE.
- IDLE -> ISSUE when S1 loads.
- ISSUE emits groups g = 0..G-1 in ascending order, skipping groups whose mask slice is 0.
- ISSUE -> IDLE after the last-beat handshake unless S1 reloads in the same cycle.
REQ-018 SHALL assert rsp_last on the highest-numbered active group.
REQ-019 SHALL emit one beat for a request with all-zero tmask: group 0, mask 0, rsp_last = 1, rsp_info preserved.
REQ-020 SHALL make a beat transfer on rsp_valid && rsp_ready.
- While rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
REQ-021 SHALL load S1 when S1 is empty or its last beat transfers in that cycle.
- S0 advances when S0 is empty or S1 loads.
- req_ready = !S0_valid || S1_load.
REQ-022 SHALL have latency: request accepted at cycle t -> first beat valid at t+2.
REQ-023 SHALL sustain one request per cycle when G = 1 and rsp_ready = 1.
- Otherwise it sustains one beat per cycle with no bubbles between consecutive requests.

Reset
REQ-024 SHALL, on reset, clear S0_valid and S1_valid, set the FSM to IDLE, and drive rsp_valid = 0, rsp_last = 0, rsp_group = 0.
- Data registers need not be reset.
REQ-025 SHALL drop any in-flight request on reset mid-issue, with no further beats emitted for it.
- req_ready = 1 in the first cycle after reset.

Configuration
REQ-026 SHALL compile MIRROR wrap logic when macro TEX_ADDR_MIRROR_EN is defined.
- Without the macro, wrap mode 2 behaves exactly as REPEAT.

Verification
(Parameters: FXD_FRAC = 20, BLEND_FRAC = 8, NUM_REQS = 4; lane 0; logdims 4/4; lod 0; lgstride 2; base 0x1000; mipoff 0.)
REQ-027 SHALL cover: point, u = v = 0x80000 -> all four addr = 0x1220, blends 0, first beat at t+2.
REQ-028 SHALL cover: bilinear, same inputs -> addr = 0x11DC / 0x11E0 / 0x121C / 0x1220, blends 0x80 / 0x80.
REQ-029 SHALL cover wrap modes, with G = 4:
- REPEAT u = 0x180000 -> x = 8.
- CLAMP u = -0x10 -> x = 0.
- CLAMP u = 0x100000 -> x = 15.
- MIRROR u = 0x140000 -> x = 11 with the macro, x = 4 without.
REQ-030 SHALL cover, with OUT_LANES = 1:
- tmask 4'b1010 -> beats for groups 1 and 3, last on group 3.
- tmask 0 -> one beat: group 0, mask 0, last = 1.
REQ-031 SHALL cover: rsp_ready low for 5 cycles mid-request -> outputs stable, no beat lost or duplicated, req_ready low once S0 and S1 are full.
REQ-032 SHALL cover:
- Reset asserted during ISSUE -> rsp_valid = 0 the next cycle and the remaining groups are never emitted.
- With OUT_LANES = 4, back-to-back requests -> one beat per cycle.
